// File: rtl/data_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_if
// Description : Per-lane SIMD data-memory request/ack bundle (LSU <-> memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 7,
    parameter int LANE_WIDTH = 16
);
    logic [LANE_WIDTH-1:0]                 mem_read_valid;
    logic [LANE_WIDTH-1:0]                 mem_write_valid;
    logic [LANE_WIDTH-1:0][ADDR_WIDTH-1:0] mem_addr;
    logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0] mem_write_data;
    logic [LANE_WIDTH-1:0]                 data_mem_ready_ack;
    logic [LANE_WIDTH-1:0]                 data_mem_write_ack;
    logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0] mem_read_data;

    modport master (
        output mem_read_valid, mem_write_valid, mem_addr, mem_write_data,
        input  data_mem_ready_ack, data_mem_write_ack, mem_read_data
    );

    modport slave (
        input  mem_read_valid, mem_write_valid, mem_addr, mem_write_data,
        output data_mem_ready_ack, data_mem_write_ack, mem_read_data
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_controller
// Description : Round-robin multiplexes SIMD lanes onto memory channels that
//               access a resettable data array. Optional DATA_MEM_STATS_EN
//               adds saturating read/write commit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_controller #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 7,
    parameter int LANE_WIDTH   = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int MEM_LATENCY  = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
`ifdef DATA_MEM_STATS_EN
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
`endif
    data_mem_if.slave   bus
);
    localparam int c_LANE_W = (LANE_WIDTH > 1) ? $clog2(LANE_WIDTH) : 1;
    localparam int c_CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int c_DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(MEM_LATENCY - 1);
    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_ACK  = 2'd2;

    logic [1:0]                            r_state      [NUM_CHANNELS];
    logic [1:0]                            w_state_next [NUM_CHANNELS];
    logic [c_LANE_W-1:0]                   r_lane       [NUM_CHANNELS];
    logic [ADDR_WIDTH-1:0]                 r_addr       [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]                 r_wdata      [NUM_CHANNELS];
    logic [c_CNT_W-1:0]                    r_cnt        [NUM_CHANNELS];
    logic [c_LANE_W-1:0]                   w_grant_lane [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]               r_op_wr;
    logic [NUM_CHANNELS-1:0]               w_grant;
    logic [NUM_CHANNELS-1:0]               w_commit;
    logic [NUM_CHANNELS-1:0]               w_release;
    logic [DATA_WIDTH-1:0]                 r_mem        [c_DEPTH];
    logic [LANE_WIDTH-1:0]                 r_rd_ack;
    logic [LANE_WIDTH-1:0]                 r_wr_ack;
    logic [LANE_WIDTH-1:0][DATA_WIDTH-1:0] r_rdata;
    logic [c_LANE_W-1:0]                   r_rr_ptr;
    logic [c_LANE_W-1:0]                   w_next_rr;
    logic [c_LANE_W-1:0]                   w_cand;
    logic                                  w_any_grant;
    logic [LANE_WIDTH-1:0]                 w_owned;
    logic [LANE_WIDTH-1:0]                 w_pending;
    logic [LANE_WIDTH-1:0]                 w_taken;

    always_comb begin
        w_owned = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (r_state[c] != c_S_IDLE) w_owned[r_lane[c]] = 1'b1;
        end
        w_pending = (bus.mem_read_valid | bus.mem_write_valid) & ~w_owned & ~(r_rd_ack | r_wr_ack);
    end

    // Idle channels pick lanes in index order; each search resumes at rr_ptr
    // and skips lanes already taken by a lower channel this cycle.
    always_comb begin
        w_taken     = '0;
        w_grant     = '0;
        w_any_grant = 1'b0;
        w_next_rr   = r_rr_ptr;
        w_cand      = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_grant_lane[c] = '0;
            if (r_state[c] == c_S_IDLE) begin
                for (int k = 0; k < LANE_WIDTH; k++) begin
                    w_cand = c_LANE_W'((int'(r_rr_ptr) + k) % LANE_WIDTH);
                    if (!w_grant[c] && w_pending[w_cand] && !w_taken[w_cand]) begin
                        w_grant[c]      = 1'b1;
                        w_grant_lane[c] = w_cand;
                        w_taken[w_cand] = 1'b1;
                        w_any_grant     = 1'b1;
                        w_next_rr       = (w_cand == c_LANE_W'(LANE_WIDTH - 1)) ? '0 : w_cand + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (rst) r_state[c] <= c_S_IDLE;
            else     r_state[c] <= w_state_next[c];
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_state_next[c] = r_state[c];
            case (r_state[c])
                c_S_IDLE: if (w_grant[c])        w_state_next[c] = c_S_BUSY;
                c_S_BUSY: if (r_cnt[c] == '0)    w_state_next[c] = c_S_ACK;
                c_S_ACK:  if (w_release[c])      w_state_next[c] = c_S_IDLE;
                default:                         w_state_next[c] = c_S_IDLE;
            endcase
        end
    end

    // Release watches only the valid of the op that was serviced.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_commit[c]  = (r_state[c] == c_S_BUSY) && (r_cnt[c] == '0);
            w_release[c] = (r_state[c] == c_S_ACK) &&
                           (r_op_wr[c] ? !bus.mem_write_valid[r_lane[c]]
                                       : !bus.mem_read_valid[r_lane[c]]);
        end
    end

    // Reads sample r_mem before this edge's writes land (read-before-write);
    // later channel iterations override earlier ones on address collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ack <= '0;
            r_wr_ack <= '0;
            r_rdata  <= '0;
            r_rr_ptr <= '0;
            r_op_wr  <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                r_lane[c]  <= '0;
                r_addr[c]  <= '0;
                r_wdata[c] <= '0;
                r_cnt[c]   <= '0;
            end
            for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_any_grant) r_rr_ptr <= w_next_rr;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (w_grant[c]) begin
                    r_lane[c]  <= w_grant_lane[c];
                    r_op_wr[c] <= bus.mem_write_valid[w_grant_lane[c]];
                    r_addr[c]  <= bus.mem_addr[w_grant_lane[c]];
                    r_wdata[c] <= bus.mem_write_data[w_grant_lane[c]];
                    r_cnt[c]   <= c_CNT_INIT;
                end else if (r_state[c] == c_S_BUSY && r_cnt[c] != '0) begin
                    r_cnt[c] <= r_cnt[c] - 1'b1;
                end
                if (w_commit[c]) begin
                    if (r_op_wr[c]) begin
                        r_mem[r_addr[c]]    <= r_wdata[c];
                        r_wr_ack[r_lane[c]] <= 1'b1;
                    end else begin
                        r_rdata[r_lane[c]]  <= r_mem[r_addr[c]];
                        r_rd_ack[r_lane[c]] <= 1'b1;
                    end
                end
                if (w_release[c]) begin
                    if (r_op_wr[c]) r_wr_ack[r_lane[c]] <= 1'b0;
                    else            r_rd_ack[r_lane[c]] <= 1'b0;
                end
            end
        end
    end

    assign bus.data_mem_ready_ack = r_rd_ack;
    assign bus.data_mem_write_ack = r_wr_ack;
    assign bus.mem_read_data      = r_rdata;

`ifdef DATA_MEM_STATS_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;
    logic [31:0] w_n_rd;
    logic [31:0] w_n_wr;
    logic [32:0] w_rd_sum;
    logic [32:0] w_wr_sum;

    always_comb begin
        w_n_rd = '0;
        w_n_wr = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_commit[c] &&  r_op_wr[c]) w_n_wr = w_n_wr + 32'd1;
            if (w_commit[c] && !r_op_wr[c]) w_n_rd = w_n_rd + 32'd1;
        end
        w_rd_sum = {1'b0, r_rd_count} + {1'b0, w_n_rd};
        w_wr_sum = {1'b0, r_wr_count} + {1'b0, w_n_wr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            r_rd_count <= w_rd_sum[32] ? '1 : w_rd_sum[31:0];
            r_wr_count <= w_wr_sum[32] ? '1 : w_wr_sum[31:0];
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif
endmodule
`default_nettype wire

// File: tb/tb_data_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_controller
// Description : Directed vector table plus multi-cycle sequences for
//               data_mem_controller (stats checks when DATA_MEM_STATS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_controller;
    localparam int DW = 64;
    localparam int AW = 7;
    localparam int LW = 16;
    localparam int NC = 4;
    localparam int ML = 2;

    typedef struct {
        int          lane;
        bit          rd;
        bit          wr;
        logic [6:0]  addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;
`ifdef DATA_MEM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    data_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW)) bus ();

    data_mem_controller #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANE_WIDTH(LW),
        .NUM_CHANNELS(NC), .MEM_LATENCY(ML)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef DATA_MEM_STATS_EN
        .rd_count (rd_count),
        .wr_count (wr_count),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_read_valid  = '0;
        bus.mem_write_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One 4-phase transaction on a single lane; lat counts edges after the
    // sampling edge until the expected ack, fall counts edges until it drops.
    task automatic txn(input int lane, input bit rd, input bit wr, input logic [6:0] addr,
                       input logic [63:0] data, output int lat, output int fall,
                       output bit wrong, output logic [63:0] rdata);
        lat = -1; fall = -1; wrong = 1'b0;
        bus.mem_addr[lane]        = addr;
        bus.mem_write_data[lane]  = data;
        bus.mem_read_valid[lane]  = rd;
        bus.mem_write_valid[lane] = wr;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (wr ? bus.data_mem_ready_ack[lane] : bus.data_mem_write_ack[lane]) wrong = 1'b1;
            if (wr ? bus.data_mem_write_ack[lane] : bus.data_mem_ready_ack[lane]) begin
                lat = n;
                break;
            end
        end
        rdata = bus.mem_read_data[lane];
        bus.mem_read_valid[lane]  = 1'b0;
        bus.mem_write_valid[lane] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (!(bus.data_mem_ready_ack[lane] | bus.data_mem_write_ack[lane])) begin
                fall = n;
                break;
            end
        end
    endtask

    vec_t        vecs[9];
    int          lat, fall;
    bit          wrong;
    logic [63:0] rdata;
    int          first_ack[LW];
    logic [63:0] got[LW];
    logic [LW-1:0] done;

    initial begin
        vecs[0] = '{3,  1'b0, 1'b1, 7'd5,   64'hDEAD_BEEF,          64'h0};
        vecs[1] = '{3,  1'b1, 1'b0, 7'd5,   64'h0,                  64'hDEAD_BEEF};
        vecs[2] = '{7,  1'b1, 1'b1, 7'd9,   64'd42,                 64'h0};
        vecs[3] = '{10, 1'b1, 1'b0, 7'd9,   64'h0,                  64'd42};
        vecs[4] = '{0,  1'b1, 1'b0, 7'd100, 64'h0,                  64'h0};
        vecs[5] = '{15, 1'b0, 1'b1, 7'd127, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[6] = '{15, 1'b1, 1'b0, 7'd127, 64'h0,                  64'hFFFF_FFFF_FFFF_FFFF};
        vecs[7] = '{5,  1'b0, 1'b1, 7'd5,   64'd123,                64'h0};
        vecs[8] = '{2,  1'b1, 1'b0, 7'd5,   64'h0,                  64'd123};

        bus.mem_read_valid  = '0;
        bus.mem_write_valid = '0;
        bus.mem_addr        = '0;
        bus.mem_write_data  = '0;
        tick();
        do_reset();

        check("reset_ready_ack", 64'(bus.data_mem_ready_ack), 64'h0);
        check("reset_write_ack", 64'(bus.data_mem_write_ack), 64'h0);
        check("reset_read_data", 64'(|bus.mem_read_data), 64'h0);

        for (int i = 0; i < 9; i++) begin
            txn(vecs[i].lane, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                lat, fall, wrong, rdata);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(ML));
            check($sformatf("vec%0d_ack_fall", i), 64'(fall), 64'h0);
            check($sformatf("vec%0d_other_ack", i), 64'(wrong), 64'h0);
            if (vecs[i].rd && !vecs[i].wr)
                check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end
        check("hold_rdata_lane3", bus.mem_read_data[3], 64'hDEAD_BEEF);
        check("rw_no_read_lane7", bus.mem_read_data[7], 64'h0);

        // Preload addr=lane with lane*3; last grant on lane 15 returns rr_ptr to 0.
        for (int l = 0; l < LW; l++)
            txn(l, 1'b0, 1'b1, 7'(l), 64'(l * 3), lat, fall, wrong, rdata);
        for (int l = 0; l < LW; l++) begin
            bus.mem_addr[l] = 7'(l);
            first_ack[l] = -1;
            got[l] = '0;
        end
        done = '0;
        bus.mem_read_valid = '1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            tick();
            for (int l = 0; l < LW; l++) begin
                if (!done[l] && bus.data_mem_ready_ack[l]) begin
                    first_ack[l] = cyc;
                    got[l] = bus.mem_read_data[l];
                    done[l] = 1'b1;
                    bus.mem_read_valid[l] = 1'b0;
                end
            end
            if (&done) break;
        end
        for (int l = 0; l < LW; l++) begin
            check($sformatf("all_lanes_ack_cycle_%0d", l), 64'(first_ack[l]), 64'(2 + 4 * (l / 4)));
            check($sformatf("all_lanes_data_%0d", l), got[l], 64'(l * 3));
        end
        tick();
        tick();

        do_reset();
        bus.mem_addr[0] = 7'd2; bus.mem_write_data[0] = 64'd11; bus.mem_write_valid[0] = 1'b1;
        bus.mem_addr[1] = 7'd2; bus.mem_read_valid[1] = 1'b1;
        tick();
        tick();
        check("rbw_early_acks", 64'({bus.data_mem_write_ack[0], bus.data_mem_ready_ack[1]}), 64'h0);
        tick();
        check("rbw_acks", 64'({bus.data_mem_write_ack[0], bus.data_mem_ready_ack[1]}), 64'h3);
        check("rbw_old_data", bus.mem_read_data[1], 64'h0);
        bus.mem_write_valid[0] = 1'b0;
        bus.mem_read_valid[1]  = 1'b0;
        tick();
        check("rbw_acks_drop", 64'({bus.data_mem_write_ack[0], bus.data_mem_ready_ack[1]}), 64'h0);
        txn(4, 1'b1, 1'b0, 7'd2, 64'h0, lat, fall, wrong, rdata);
        check("rbw_new_data", rdata, 64'd11);

        for (int i = 0; i < 4; i++) begin
            bus.mem_addr[i] = 7'(20 + i);
            bus.mem_write_data[i] = 64'(100 + i);
            bus.mem_write_valid[i] = 1'b1;
        end
        tick();
        rst = 1'b1;
        bus.mem_write_valid = '0;
        tick();
        check("midrst_write_ack", 64'(bus.data_mem_write_ack), 64'h0);
        check("midrst_ready_ack", 64'(bus.data_mem_ready_ack), 64'h0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            txn(i, 1'b1, 1'b0, 7'(20 + i), 64'h0, lat, fall, wrong, rdata);
            check($sformatf("midrst_lat_%0d", i), 64'(lat), 64'(ML));
            check($sformatf("midrst_data_%0d", i), rdata, 64'h0);
        end

`ifdef DATA_MEM_STATS_EN
        do_reset();
        check("stats_rst_rd", 64'(rd_count), 64'h0);
        check("stats_rst_wr", 64'(wr_count), 64'h0);
        for (int i = 0; i < 6; i++)
            txn(i, 1'b0, 1'b1, 7'(40 + i), 64'(i), lat, fall, wrong, rdata);
        for (int i = 0; i < 10; i++)
            txn(i, 1'b1, 1'b0, 7'(40 + i), 64'h0, lat, fall, wrong, rdata);
        check("stats_rd", 64'(rd_count), 64'd10);
        check("stats_wr", 64'(wr_count), 64'd6);
        do_reset();
        check("stats_rd_after_rst", 64'(rd_count), 64'h0);
        check("stats_wr_after_rst", 64'(wr_count), 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
